alu_sequencer: RTL and testbench

- Fetch/decode/execute controller for the 8-bit CPU.
- Fetches 16-bit instruction words from a synchronous program memory and holds a 4x8 register file.
- Drives the existing combinational ALU through its `alu_a`/`alu_b`/`alu_sel` interface and writes back `alu_result`/`alu_carry`.
- Sits between program memory and the ALU; it is the only master of the ALU.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/alu_sequencer_if.sv | 27 ++
 rtl/reg_file_4x8.sv | 25 ++
 rtl/alu_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU sequencer slice.
// Holds opcode encodings, FSM state encoding and instruction field positions.
//   instr[15:13] op | [12:11] rd | [10:9] rs | [8] unused | [7:0] imm
//   op 111: bit12=1 HALT, bit12=0 JC (jump to imm when carry_flag set)
package cpu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_CTL = 3'b111;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALTED = 3'd5;

  localparam int OP_HI    = 15;
  localparam int OP_LO    = 13;
  localparam int RD_HI    = 12;
  localparam int RD_LO    = 11;
  localparam int RS_HI    = 10;
  localparam int RS_LO    = 9;
  localparam int SPARE    = 8;
  localparam int IMM_HI   = 7;
  localparam int IMM_LO   = 0;
  localparam int HALT_BIT = 12;

endpackage

// File: rtl/alu_sequencer_if.sv
// Bus between the sequencer, program memory and the combinational ALU.
//   master (sequencer): drives pc_out/mem_en and alu_a/alu_b/alu_sel,
//                       receives instr_in and alu_result/alu_carry.
//   slave  (memory+ALU side): the opposite directions.
interface alu_sequencer_if #(
  parameter int PC_W = 8,
  parameter int IW   = 16
);
  logic [PC_W-1:0] pc_out;
  logic            mem_en;
  logic [IW-1:0]   instr_in;
  logic [7:0]      alu_a;
  logic [7:0]      alu_b;
  logic [2:0]      alu_sel;
  logic [7:0]      alu_result;
  logic            alu_carry;

  modport master (
    output pc_out, mem_en, alu_a, alu_b, alu_sel,
    input  instr_in, alu_result, alu_carry
  );

  modport slave (
    input  pc_out, mem_en, alu_a, alu_b, alu_sel,
    output instr_in, alu_result, alu_carry
  );
endinterface

// File: rtl/reg_file_4x8.sv
// 4 x 8-bit register file.
//   clk, rst (async, active low, clears all registers)
//   we/waddr/wdata : synchronous write port
//   raddr_a/rdata_a, raddr_b/rdata_b : combinational read ports
module reg_file_4x8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr_a,
  input  logic [1:0] raddr_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b
);
  logic [3:0][7:0] regs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    regs <= '0;
    else if (we) regs[waddr] <= wdata;
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller for the 8-bit CPU.
//   clk, rst (async, active low), start (one-cycle run pulse)
//   bus        : program memory (pc_out/mem_en/instr_in) and ALU
//                (alu_a/alu_b/alu_sel/alu_result/alu_carry)
//   carry_flag : carry captured at the last ALU writeback
//   data_out   : last value written to any register
//   busy       : FETCH/DECODE/EXEC/WB;  halted : HALTED
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int IW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  alu_sequencer_if.master bus,
  output logic            carry_flag,
  output logic [7:0]      data_out,
  output logic            busy,
  output logic            halted
);
  logic [2:0]      state;
  logic [PC_W-1:0] pc;
  logic [2:0]      ir_op;
  logic [1:0]      ir_rd;
  logic [7:0]      ir_imm;
  logic [7:0]      alu_a_q, alu_b_q;
  logic [2:0]      alu_sel_q;

  // Fields decoded straight off the memory data; only meaningful in DECODE,
  // which is the cycle instr_in is valid.
  logic [IW-1:0] instr;
  logic [2:0]    d_op;
  logic [1:0]    d_rd, d_rs;
  logic [7:0]    d_imm;
  logic          unused_spare;
  logic [7:0]    rdata_a, rdata_b, wdata;

  assign instr        = bus.instr_in;
  assign d_op         = instr[OP_HI:OP_LO];
  assign d_rd         = instr[RD_HI:RD_LO];
  assign d_rs         = instr[RS_HI:RS_LO];
  assign d_imm        = instr[IMM_HI:IMM_LO];
  assign unused_spare = instr[SPARE];

  // Operands are read in DECODE and registered into alu_a/alu_b, so a WB
  // write to the same register (rd==rs) never feeds back into EXEC.
  assign wdata = (ir_op == OP_LDI) ? ir_imm : bus.alu_result;

  reg_file_4x8 u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (state == WB),
    .waddr   (ir_rd),
    .wdata   (wdata),
    .raddr_a (d_rd),
    .raddr_b (d_rs),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= '0;
      ir_op      <= '0;
      ir_rd      <= '0;
      ir_imm     <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      carry_flag <= 1'b0;
      data_out   <= '0;
    end else begin
      case (state)
        IDLE, HALTED: if (start) begin
          pc    <= '0;
          state <= FETCH;
        end
        FETCH: state <= DECODE;
        DECODE: begin
          ir_op  <= d_op;
          ir_rd  <= d_rd;
          ir_imm <= d_imm;
          if (d_op == OP_CTL) begin
            if (instr[HALT_BIT]) state <= HALTED;
            else begin
              pc    <= carry_flag ? d_imm[PC_W-1:0] : pc + PC_W'(1);
              state <= FETCH;
            end
          end else if (d_op == OP_LDI) begin
            state <= WB;
          end else begin
            // ALU inputs change only here, so they hold outside EXEC.
            alu_a_q   <= rdata_a;
            alu_b_q   <= rdata_b;
            alu_sel_q <= d_op;
            state     <= EXEC;
          end
        end
        EXEC: state <= WB;
        WB: begin
          if (ir_op == OP_LDI) data_out <= ir_imm;
          else begin
            data_out   <= bus.alu_result;
            carry_flag <= bus.alu_carry;
          end
          pc    <= pc + PC_W'(1);
          state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pc_out  = pc;
  assign bus.mem_en  = (state == FETCH);
  assign bus.alu_a   = alu_a_q;
  assign bus.alu_b   = alu_b_q;
  assign bus.alu_sel = alu_sel_q;
  assign busy        = (state == FETCH) || (state == DECODE) ||
                       (state == EXEC)  || (state == WB);
  assign halted      = (state == HALTED);
endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  import cpu_pkg::*;

  logic       clk, rst, start;
  logic       carry_flag, busy, halted;
  logic [7:0] data_out;

  alu_sequencer_if #(.PC_W(8), .IW(16)) bus ();

  alu_sequencer #(.PC_W(8), .IW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .carry_flag (carry_flag),
    .data_out   (data_out),
    .busy       (busy),
    .halted     (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous program memory
  logic [15:0] mem [256];
  always @(posedge clk) if (bus.mem_en) bus.instr_in <= mem[bus.pc_out];

  // Reference ALU (combinational)
  always_comb begin
    bus.alu_result = 8'h00;
    bus.alu_carry  = 1'b0;
    case (bus.alu_sel)
      OP_ADD: {bus.alu_carry, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      OP_SUB: {bus.alu_carry, bus.alu_result} = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      OP_AND: bus.alu_result = bus.alu_a & bus.alu_b;
      OP_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
      OP_XOR: bus.alu_result = bus.alu_a ^ bus.alu_b;
      OP_NOT: bus.alu_result = ~bus.alu_a;
      default: ;
    endcase
  end

  function automatic logic [15:0] ins(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, 1'b0, imm};
  endfunction
  localparam logic [15:0] HALT_W = 16'hF000;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected final state of each halting program
  typedef struct { string name; logic [7:0] d; logic c; } exp_t;
  exp_t sb[$];
  exp_t e;
  logic halt_q = 1'b0;

  always @(negedge clk) begin
    if (halted && !halt_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_halt: got halt expected none");
      end else begin
        e = sb.pop_front();
        chk({e.name, "_data_out"}, {24'h0, data_out}, {24'h0, e.d});
        chk({e.name, "_carry"}, {31'h0, carry_flag}, {31'h0, e.c});
      end
    end
    halt_q = halted;
  end

  // Per-edge snapshots of a program run, index 0 = edge where start sampled
  logic [7:0] s_a [64];
  logic [7:0] s_b [64];
  logic [2:0] s_sel [64];
  logic [7:0] s_pc [64];
  logic       s_men [64];

  task automatic snap(input int n);
    s_a[n] = bus.alu_a; s_b[n] = bus.alu_b; s_sel[n] = bus.alu_sel;
    s_pc[n] = bus.pc_out; s_men[n] = bus.mem_en;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_prog(input string name, input int exp_n, input int inject_at);
    int n = 0;
    pulse_start();
    snap(0);
    while (!halted && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      snap(n);
      start = (n == inject_at);
    end
    start = 1'b0;
    chk({name, "_halt_edges"}, n, exp_n);
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = HALT_W;
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    clear_mem();
    #12;
    chk("rst_flags", {28'h0, busy, halted, bus.mem_en, carry_flag}, 32'h0);
    chk("rst_pc", {24'h0, bus.pc_out}, 32'h0);
    chk("rst_data", {24'h0, data_out}, 32'h0);
    chk("rst_alu", {13'h0, bus.alu_sel, bus.alu_a, bus.alu_b}, 32'h0);
    @(negedge clk) rst = 1'b1;

    // LDI r0,5; LDI r1,3; ADD r0,r1; HALT
    mem[0] = ins(OP_LDI, 0, 0, 8'h05);
    mem[1] = ins(OP_LDI, 1, 0, 8'h03);
    mem[2] = ins(OP_ADD, 0, 1, 8'h00);
    mem[3] = HALT_W;
    sb.push_back('{"add", 8'h08, 1'b0});
    run_prog("add", 12, 0);
    chk("add_first_fetch", {23'h0, s_men[0], s_pc[0]}, {23'h0, 1'b1, 8'h00});
    chk("add_decode_men", {31'h0, s_men[1]}, 32'h0);

    // LDI r0,CC; LDI r1,AA; AND r0,r1; HALT (started from HALTED)
    mem[0] = ins(OP_LDI, 0, 0, 8'hCC);
    mem[1] = ins(OP_LDI, 1, 0, 8'hAA);
    mem[2] = ins(OP_AND, 0, 1, 8'h00);
    sb.push_back('{"and", 8'h88, 1'b0});
    run_prog("and", 12, 0);
    chk("and_exec_alu", {13'h0, s_sel[8], s_a[8], s_b[8]}, {13'h0, 3'b010, 8'hCC, 8'hAA});
    chk("and_alu_hold", {13'h0, s_sel[10], s_a[10], s_b[10]}, {13'h0, 3'b010, 8'hCC, 8'hAA});

    // Registers retained across restart: r0=88, r1=AA -> 0x132
    mem[0] = ins(OP_ADD, 0, 1, 8'h00);
    mem[1] = HALT_W;
    mem[2] = HALT_W;
    sb.push_back('{"retain", 8'h32, 1'b1});
    run_prog("retain", 6, 0);
    chk("retain_fetch0", {23'h0, s_men[0], s_pc[0]}, {23'h0, 1'b1, 8'h00});

    // Carry + JC, with a start pulse while busy
    mem[0] = ins(OP_LDI, 0, 0, 8'hFF);
    mem[1] = ins(OP_LDI, 1, 0, 8'h01);
    mem[2] = ins(OP_ADD, 0, 1, 8'h00);
    mem[3] = {3'b111, 1'b0, 4'h0, 8'h10};
    mem[4] = ins(OP_LDI, 2, 0, 8'h55);
    mem[8'h10] = HALT_W;
    sb.push_back('{"jc", 8'h00, 1'b1});
    run_prog("jc", 14, 4);
    chk("jc_target_fetch", {23'h0, s_men[12], s_pc[12]}, {23'h0, 1'b1, 8'h10});
    chk("jc_decode_men", {31'h0, s_men[11]}, 32'h0);

    // Reset asserted during EXEC of the ADD
    pulse_start();
    repeat (8) @(posedge clk);
    #1;
    chk("abort_exec_alu", {13'h0, bus.alu_sel, bus.alu_a, bus.alu_b}, {13'h0, OP_ADD, 8'hFF, 8'h01});
    #2 rst = 1'b0;
    #1;
    chk("abort_flags", {28'h0, busy, halted, bus.mem_en, carry_flag}, 32'h0);
    chk("abort_alu", {13'h0, bus.alu_sel, bus.alu_a, bus.alu_b}, 32'h0);
    chk("abort_pc_data", {16'h0, bus.pc_out, data_out}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_idle", {29'h0, busy, halted, bus.mem_en}, 32'h0);
    chk("abort_no_wb", {24'h0, data_out}, 32'h0);

    // 256 LDIs, no HALT: pc wraps FF -> 00
    for (int i = 0; i < 256; i++) mem[i] = ins(OP_LDI, 2'(i), 2'd0, 8'(i));
    begin
      bit prev_ff = 1'b0;
      bit found = 1'b0;
      pulse_start();
      for (int k = 0; k < 1000 && !found; k++) begin
        @(posedge clk);
        #1;
        if (bus.mem_en) begin
          if (prev_ff) begin
            chk("wrap_pc", {24'h0, bus.pc_out}, 32'h0);
            chk("wrap_data", {24'h0, data_out}, 32'hFF);
            found = 1'b1;
          end
          prev_ff = (bus.pc_out == 8'hFF);
        end
      end
      if (!found) begin
        checks++;
        errors++;
        $display("FAIL wrap_timeout: got no wrap fetch expected fetch of 0x00");
      end
    end
    rst = 1'b0;
    #20;
    chk("sb_drained", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
